// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK symbol scheduler and its sibling
// keyed-modulation controllers.
package qpsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_t;

  // Dibit {I,Q} to carrier phase mapping (Gray coded around the circle)
  localparam logic [1:0] PH_45  = 2'b00;
  localparam logic [1:0] PH_135 = 2'b01;
  localparam logic [1:0] PH_225 = 2'b11;
  localparam logic [1:0] PH_315 = 2'b10;

  localparam int unsigned SYM_LEN_DEF = 512;

endpackage

// File: rtl/sym_timer.sv
// Symbol-period counter: counts 0..SYM_LEN-1 while run is high and flags the
// last cycle of each symbol with a terminal-count pulse.
module sym_timer #(
  parameter int unsigned SYM_LEN = 512,
  parameter int unsigned CNT_W   = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic run,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_LEN - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tc = run && (cnt == LAST);

endmodule

// File: rtl/qpsk_sym_ctrl.sv
// QPSK symbol scheduler: packs a serial bit stream into dibits and presents
// one dibit per symbol period to the carrier phase mux.
module qpsk_sym_ctrl
  import qpsk_pkg::*;
#(
  parameter int unsigned SYM_LEN = SYM_LEN_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic       sym_strobe,
  output logic [1:0] phase_sel,
  output logic       carrier_en,
  output logic       busy,
  output logic       underrun
);

  state_t     state, state_nxt;
  logic [1:0] nbuf, nbuf_nxt;
  logic [1:0] buf_q, buf_nxt;
  logic [1:0] phase_nxt;
  logic       strobe_nxt, carrier_nxt, underrun_nxt;
  logic       tmr_clr, tmr_run, tc;
  logic       accept;

  sym_timer #(
    .SYM_LEN (SYM_LEN),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .run     (tmr_run),
    .tc      (tc)
  );

  assign bit_ready = enable && ((state == LOAD) || (state == RUN)) && (nbuf < 2'd2);
  assign accept    = bit_valid && bit_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      nbuf       <= 2'd0;
      buf_q      <= 2'b00;
      phase_sel  <= PH_45;
      sym_strobe <= 1'b0;
      carrier_en <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      nbuf       <= nbuf_nxt;
      buf_q      <= buf_nxt;
      phase_sel  <= phase_nxt;
      sym_strobe <= strobe_nxt;
      carrier_en <= carrier_nxt;
      underrun   <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    nbuf_nxt     = nbuf;
    buf_nxt      = buf_q;
    phase_nxt    = phase_sel;
    strobe_nxt   = 1'b0;
    carrier_nxt  = carrier_en;
    underrun_nxt = underrun;
    tmr_clr      = 1'b0;
    tmr_run      = 1'b0;

    // First bit of a dibit lands in I (MSB), second in Q
    if (accept) begin
      if (nbuf == 2'd0) begin
        buf_nxt[1] = bit_in;
      end else begin
        buf_nxt[0] = bit_in;
      end
      nbuf_nxt = nbuf + 2'd1;
    end

    case (state)
      IDLE: begin
        tmr_clr     = 1'b1;
        nbuf_nxt    = 2'd0;
        carrier_nxt = 1'b0;
        phase_nxt   = PH_45;
        if (enable) begin
          state_nxt    = LOAD;
          underrun_nxt = 1'b0;
        end
      end
      LOAD: begin
        tmr_clr = 1'b1;
        if (!enable) begin
          state_nxt = IDLE;
          nbuf_nxt  = 2'd0;
        end else if (nbuf_nxt == 2'd2) begin
          phase_nxt   = buf_nxt;
          strobe_nxt  = 1'b1;
          carrier_nxt = 1'b1;
          nbuf_nxt    = 2'd0;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        tmr_run = 1'b1;
        // nbuf_nxt already includes a bit accepted on the boundary edge
        if (tc) begin
          if (nbuf_nxt == 2'd2) begin
            phase_nxt  = buf_nxt;
            strobe_nxt = 1'b1;
            nbuf_nxt   = 2'd0;
          end else if (enable) begin
            underrun_nxt = 1'b1;
          end else begin
            state_nxt   = IDLE;
            nbuf_nxt    = 2'd0;
            carrier_nxt = 1'b0;
            phase_nxt   = PH_45;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_qpsk_sym_ctrl.sv
// Bench for qpsk_sym_ctrl with SYM_LEN=8: a vector table for the basic
// stream, directed corner sequences, and a randomized run against a model.
module tb_qpsk_sym_ctrl;
  import qpsk_pkg::*;

  localparam int unsigned SL = 8;

  logic       clk = 1'b0;
  logic       reset_n, enable, bit_in, bit_valid;
  logic       bit_ready, sym_strobe, carrier_en, busy, underrun;
  logic [1:0] phase_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qpsk_sym_ctrl #(.SYM_LEN(SL), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .sym_strobe (sym_strobe),
    .phase_sel  (phase_sel),
    .carrier_en (carrier_en),
    .busy       (busy),
    .underrun   (underrun)
  );

  // Reference model: mode 0=idle 1=loading 2=transmitting, bits in a queue
  int         m_mode = 0;
  logic       q[$];
  int         m_pos = 0;
  logic [1:0] m_ph = 2'b00;
  logic       m_stb = 1'b0, m_car = 1'b0, m_und = 1'b0;

  function automatic logic m_ready();
    return enable && (m_mode != 0) && (q.size() < 2);
  endfunction

  task automatic model_edge();
    logic acc;
    acc = bit_valid && m_ready();
    m_stb = 1'b0;
    if (!reset_n) begin
      m_mode = 0; q.delete(); m_pos = 0; m_ph = 2'b00; m_car = 1'b0; m_und = 1'b0;
    end else if (m_mode == 0) begin
      if (enable) begin m_mode = 1; m_und = 1'b0; end
    end else if (m_mode == 1) begin
      if (!enable) begin
        q.delete(); m_mode = 0;
      end else if (acc) begin
        q.push_back(bit_in);
        if (q.size() == 2) begin
          m_ph = {q[0], q[1]}; q.delete(); m_stb = 1'b1; m_car = 1'b1; m_pos = 0; m_mode = 2;
        end
      end
    end else begin
      if (acc) q.push_back(bit_in);
      if (m_pos == int'(SL) - 1) begin
        m_pos = 0;
        if (q.size() == 2) begin
          m_ph = {q[0], q[1]}; q.delete(); m_stb = 1'b1;
        end else if (enable) begin
          m_und = 1'b1;
        end else begin
          q.delete(); m_mode = 0; m_car = 1'b0; m_ph = 2'b00;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic v, input logic b);
    reset_n = r; enable = e; bit_valid = v; bit_in = b;
    #1;
  endtask

  task automatic clock();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic b, input string nm);
    drive(r, e, v, b);
    chk({nm, "_ready"}, 8'(bit_ready), 8'(m_ready()));
    clock();
    chk({nm, "_strobe"}, 8'(sym_strobe), 8'(m_stb));
    chk({nm, "_phase"}, 8'(phase_sel), 8'(m_ph));
    chk({nm, "_carrier"}, 8'(carrier_en), 8'(m_car));
    chk({nm, "_busy"}, 8'(busy), 8'(m_mode != 0));
    chk({nm, "_underrun"}, 8'(underrun), 8'(m_und));
  endtask

  task automatic start_run(input logic b0, input logic b1, input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b0, nm);
    step(1'b1, 1'b1, 1'b0, 1'b0, nm);
    step(1'b1, 1'b1, 1'b1, b0, nm);
    step(1'b1, 1'b1, 1'b1, b1, nm);
    chk({nm, "_first_strobe"}, 8'(sym_strobe), 8'd1);
    chk({nm, "_first_phase"}, 8'(phase_sel), 8'({b0, b1}));
  endtask

  typedef struct {
    logic       r, e, v, b;
    logic       rdy;
    logic [1:0] ph;
    logic       stb, car, bsy, und;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic e, input logic v, input logic b,
                              input logic rdy, input logic [1:0] ph, input logic stb,
                              input logic car, input logic bsy, input logic und);
    vec_t t;
    t.r = r; t.e = e; t.v = v; t.b = b; t.rdy = rdy; t.ph = ph;
    t.stb = stb; t.car = car; t.bsy = bsy; t.und = und;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   ns;
    bit   found;
    logic e_r;

    // Basic stream 1,0,0,1,1,1: dibits 10,01,11 on strobes 8 cycles apart
    tbl.push_back(mk(0, 0, 0, 0, 0, PH_45, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, PH_45, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, PH_45, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, PH_315, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, PH_315, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, PH_315, 0, 1, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 1, 1, 0, PH_315, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, PH_135, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, PH_135, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, PH_135, 0, 1, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 1, 1, 0, PH_135, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, PH_225, 1, 1, 1, 0));

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].b);
      chk($sformatf("tbl%0d_ready", i), 8'(bit_ready), 8'(tbl[i].rdy));
      clock();
      chk($sformatf("tbl%0d_phase", i), 8'(phase_sel), 8'(tbl[i].ph));
      chk($sformatf("tbl%0d_strobe", i), 8'(sym_strobe), 8'(tbl[i].stb));
      chk($sformatf("tbl%0d_carrier", i), 8'(carrier_en), 8'(tbl[i].car));
      chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tbl[i].bsy));
      chk($sformatf("tbl%0d_underrun", i), 8'(underrun), 8'(tbl[i].und));
    end

    // Underrun: starve the buffer for 20 cycles, then refill
    start_run(1'b0, 1'b1, "ur");
    ns = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, "ur_starve");
      if (sym_strobe) ns++;
    end
    chk("ur_no_strobe", 8'(ns), 8'd0);
    chk("ur_flag", 8'(underrun), 8'd1);
    chk("ur_phase_held", 8'(phase_sel), 8'(PH_135));
    step(1'b1, 1'b1, 1'b1, 1'b1, "ur_fill");
    step(1'b1, 1'b1, 1'b1, 1'b1, "ur_fill");
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, "ur_wait");
      if (sym_strobe) found = 1'b1;
    end
    chk("ur_reload_found", 8'(found), 8'd1);
    chk("ur_reload_phase", 8'(phase_sel), 8'(PH_225));

    // Second bit accepted on the boundary edge itself
    start_run(1'b1, 1'b1, "se");
    step(1'b1, 1'b1, 1'b1, 1'b0, "se_bit0");
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 1'b0, "se_gap");
    step(1'b1, 1'b1, 1'b1, 1'b1, "se_bit1");
    chk("se_strobe", 8'(sym_strobe), 8'd1);
    chk("se_phase", 8'(phase_sel), 8'(PH_135));
    chk("se_no_underrun", 8'(underrun), 8'd0);

    // Graceful stop with a full dibit buffered
    start_run(1'b1, 1'b0, "gs2");
    step(1'b1, 1'b1, 1'b1, 1'b1, "gs2_fill");
    step(1'b1, 1'b1, 1'b1, 1'b1, "gs2_fill");
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 1'b0, "gs2_drain");
    chk("gs2_last_strobe", 8'(sym_strobe), 8'd1);
    chk("gs2_last_phase", 8'(phase_sel), 8'(PH_225));
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0, 1'b0, "gs2_last_sym");
    chk("gs2_carrier_held", 8'(carrier_en), 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, "gs2_end");
    chk("gs2_idle_busy", 8'(busy), 8'd0);
    chk("gs2_idle_carrier", 8'(carrier_en), 8'd0);
    chk("gs2_idle_phase", 8'(phase_sel), 8'(PH_45));

    // Graceful stop with a partial dibit: bit discarded at the boundary
    start_run(1'b0, 1'b0, "gs1");
    step(1'b1, 1'b1, 1'b1, 1'b1, "gs1_bit");
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 1'b0, "gs1_drain");
    chk("gs1_still_busy", 8'(busy), 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, "gs1_end");
    chk("gs1_idle_busy", 8'(busy), 8'd0);
    chk("gs1_idle_carrier", 8'(carrier_en), 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "gs1_reen");
    step(1'b1, 1'b1, 1'b1, 1'b1, "gs1_reen");
    step(1'b1, 1'b1, 1'b1, 1'b0, "gs1_reen");
    chk("gs1_discarded", 8'(phase_sel), 8'(PH_315));

    // Abort in LOAD after one bit, then re-enable
    step(1'b0, 1'b0, 1'b0, 1'b0, "ab");
    step(1'b1, 1'b1, 1'b0, 1'b0, "ab");
    step(1'b1, 1'b1, 1'b1, 1'b0, "ab_bit");
    step(1'b1, 1'b0, 1'b0, 1'b0, "ab_drop");
    chk("ab_idle", 8'(busy), 8'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("ab_ready_idle", 8'(bit_ready), 8'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, "ab_reen");
    step(1'b1, 1'b1, 1'b1, 1'b1, "ab_reen");
    step(1'b1, 1'b1, 1'b1, 1'b1, "ab_reen");
    chk("ab_first_dibit", 8'(phase_sel), 8'(PH_225));
    chk("ab_strobe", 8'(sym_strobe), 8'd1);

    // Reset mid-symbol with underrun already set
    start_run(1'b1, 1'b0, "rs");
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 1'b0, "rs_starve");
    chk("rs_underrun_set", 8'(underrun), 8'd1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, "rs_mid");
    step(1'b0, 1'b1, 1'b1, 1'b1, "rs_pulse");
    chk("rs_phase", 8'(phase_sel), 8'd0);
    chk("rs_carrier", 8'(carrier_en), 8'd0);
    chk("rs_busy", 8'(busy), 8'd0);
    chk("rs_underrun", 8'(underrun), 8'd0);
    chk("rs_strobe", 8'(sym_strobe), 8'd0);

    // Randomized traffic against the model
    e_r = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) e_r = ~e_r;
      step(($urandom_range(0, 499) != 0), e_r, ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
